// File: rtl/box_plotter.sv
// box_plotter
//
// Pixel-sweep engine feeding a 160x120 VGA adapter. It arbitrates draw
// requests from two players and a full-screen clear. For each accepted
// operation it emits one pixel per cycle in row-major order, then pulses done.
//
// Ports
//   clk, resetn          : clock, synchronous active-low reset
//   req0/1, step0/1,
//   lane0/1, col0/1      : player draw requests. Fields are held stable until ack.
//   clear_req            : full-screen clear request, held until clear_ack
//   ack0/1, clear_ack    : combinational accept strobes, asserted only in IDLE
//   x, y, colour, plot   : registered pixel stream to the VGA adapter
//   busy                 : high while a sweep is in progress
//   done                 : one-cycle pulse in the first IDLE cycle after an op
//   bad                  : pulses with done when the accepted step was > 32
module box_plotter #(
  parameter int         BOX_W     = 16,
  parameter int         BOX_H     = 3,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       req1,
  input  logic [5:0] step0,
  input  logic [5:0] step1,
  input  logic       lane0,
  input  logic       lane1,
  input  logic [2:0] col0,
  input  logic [2:0] col1,
  input  logic       clear_req,
  output logic       ack0,
  output logic       ack1,
  output logic       clear_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       bad
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR} state_t;

  state_t     state_q;
  logic       rr_q;        // 1: player 1 was granted last
  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic [2:0] col_q;
  logic [7:0] cx_q;        // offset of the pixel currently on the outputs
  logic [6:0] cy_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       done_q;
  logic       bad_q;

  // Arbitration: clear first, then round-robin between the players.
  logic idle;
  logic gnt_clr, gnt0, gnt1;

  assign idle    = (state_q == S_IDLE) && resetn;
  assign gnt_clr = idle && clear_req;
  assign gnt0    = idle && !clear_req && req0 && (!req1 || rr_q);
  assign gnt1    = idle && !clear_req && req1 && (!req0 || !rr_q);

  // Fields of the granted player
  logic [5:0] sel_step;
  logic       sel_lane;
  logic [2:0] sel_col;
  logic [6:0] step7;
  logic [7:0] x0_d;
  logic [6:0] y0_d;
  logic       step_bad;

  assign sel_step = gnt1 ? step1 : step0;
  assign sel_lane = gnt1 ? lane1 : lane0;
  assign sel_col  = gnt1 ? col1  : col0;
  assign step_bad = sel_step > 6'd32;
  assign x0_d     = (gnt1 ? 8'd80 : 8'd0) + (sel_lane ? 8'd48 : 8'd16);
  // 117 - 3*step. Only the low 7 bits reach the y output, and modular
  // arithmetic keeps those bits identical to the 8-bit computation.
  assign step7    = {1'b0, sel_step};
  assign y0_d     = 7'd117 - step7 * 7'd3;

  // Sweep bounds depend on whether we are filling a box or the screen.
  logic [7:0] x_last;
  logic [6:0] y_last;
  logic       row_end;
  logic       sweep_end;
  logic [7:0] cx_d;
  logic [6:0] cy_d;

  assign x_last    = (state_q == S_CLEAR) ? 8'd159 : 8'(BOX_W - 1);
  assign y_last    = (state_q == S_CLEAR) ? 7'd119 : 7'(BOX_H - 1);
  assign row_end   = (cx_q == x_last);
  assign sweep_end = row_end && (cy_q == y_last);
  assign cx_d      = row_end ? 8'd0 : cx_q + 8'd1;
  assign cy_d      = row_end ? cy_q + 7'd1 : cy_q;

  // The accept edge already loads pixel (0,0) onto the outputs. This places the
  // first plot in the cycle right after ack, with no gaps in the sweep.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b1;
      x0_q     <= '0;
      y0_q     <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_clr) begin
            x0_q     <= '0;
            y0_q     <= '0;
            col_q    <= BG_COLOUR;
            cx_q     <= '0;
            cy_q     <= '0;
            state_q  <= S_CLEAR;
            plot_q   <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= BG_COLOUR;
          end else if (gnt0 || gnt1) begin
            rr_q  <= gnt1;
            x0_q  <= x0_d;
            y0_q  <= y0_d;
            col_q <= sel_col;
            cx_q  <= '0;
            cy_q  <= '0;
            if (step_bad) begin
              // Acknowledge and report, but never touch the screen.
              done_q <= 1'b1;
              bad_q  <= 1'b1;
            end else begin
              state_q  <= S_DRAW;
              plot_q   <= 1'b1;
              x_q      <= x0_d;
              y_q      <= y0_d;
              colour_q <= sel_col;
            end
          end
        end
        S_DRAW, S_CLEAR: begin
          if (sweep_end) begin
            state_q <= S_IDLE;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            x_q  <= x0_q + cx_d;
            y_q  <= y0_q + cy_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0      = gnt0;
  assign ack1      = gnt1;
  assign clear_ack = gnt_clr;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign bad       = bad_q;

endmodule

// File: tb/tb_box_plotter.sv
// Testbench for box_plotter. A reference model predicts, for every cycle, the
// complete output bundle from the arbitration rules and the box geometry.
// Directed scenarios follow, then randomized requests with random resets.
module tb_box_plotter;
  localparam int W = 16;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, clear_req = 1'b0;
  logic [5:0] step0 = '0, step1 = '0;
  logic       lane0 = 1'b0, lane1 = 1'b0;
  logic [2:0] col0 = '0, col1 = '0;
  logic       ack0, ack1, clear_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, bad;

  box_plotter #(.BOX_W(W), .BOX_H(H), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .step0(step0), .step1(step1),
    .lane0(lane0), .lane1(lane1), .col0(col0), .col1(col1),
    .clear_req(clear_req), .ack0(ack0), .ack1(ack1), .clear_ack(clear_ack),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .done(done), .bad(bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       plot;
    bit       busy;
    bit       done;
    bit       bad;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] col;
  } rec_t;

  rec_t     exp_q[$];          // expected outputs for upcoming cycles
  bit       m_rr_p1 = 1'b1;
  bit [7:0] m_lx;
  bit [6:0] m_ly;
  bit [2:0] m_lc;
  bit       check_en = 1'b0;

  // Observed sweep statistics, snapshotted whenever done pulses
  int sw_plots, sw_fx, sw_fy, sw_lx, sw_ly;
  bit sw_first;
  int dn_plots, dn_fx, dn_fy, dn_lx, dn_ly;

  function automatic bit [7:0] geo_x(input int p, input bit lane);
    return 8'(80 * p + (lane ? 48 : 16));
  endfunction

  function automatic bit [6:0] geo_y(input int step);
    return 7'(117 - 3 * step);
  endfunction

  task automatic push_sweep(input int bx, input int by, input int w, input int h,
                            input bit [2:0] c);
    rec_t r;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        r.plot = 1; r.busy = 1; r.done = 0; r.bad = 0;
        r.x = 8'(bx + xx); r.y = 7'(by + yy); r.col = c;
        exp_q.push_back(r);
      end
    r = '{default: 0};
    r.done = 1;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    rec_t r;
    bit   g0, g1, gc;
    int   st;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    else r = '{default: 0};
    if (check_en) begin
      chk("plot", plot, r.plot);
      chk("busy", busy, r.busy);
      chk("done", done, r.done);
      chk("bad", bad, r.bad);
      if (r.plot) begin m_lx = r.x; m_ly = r.y; m_lc = r.col; end
      chk("x", x, m_lx);
      chk("y", y, m_ly);
      chk("colour", colour, m_lc);
      if (done === 1'b1) begin
        dn_plots = sw_plots; dn_fx = sw_fx; dn_fy = sw_fy; dn_lx = sw_lx; dn_ly = sw_ly;
      end
      if (plot === 1'b1) begin
        if (sw_first) begin sw_fx = x; sw_fy = y; sw_first = 0; end
        sw_lx = x; sw_ly = y; sw_plots++;
      end
    end
    if (!resetn) begin
      if (check_en) begin
        chk("ack0_in_reset", ack0, 0);
        chk("ack1_in_reset", ack1, 0);
        chk("clear_ack_in_reset", clear_ack, 0);
      end
      exp_q.delete();
      m_rr_p1 = 1'b1;
      m_lx = 0; m_ly = 0; m_lc = 0;
      check_en = 1'b1;
    end else if (check_en) begin
      g0 = 0; g1 = 0; gc = 0;
      if (!r.busy) begin
        if (clear_req) gc = 1;
        else if (req0 && req1) begin
          if (m_rr_p1) g0 = 1; else g1 = 1;
        end else if (req0) g0 = 1;
        else if (req1) g1 = 1;
      end
      chk("ack0", ack0, g0);
      chk("ack1", ack1, g1);
      chk("clear_ack", clear_ack, gc);
      if (gc) push_sweep(0, 0, 160, 120, 3'b000);
      else if (g0 || g1) begin
        m_rr_p1 = g1;
        st = g1 ? int'(step1) : int'(step0);
        if (st > 32) begin
          r = '{default: 0};
          r.done = 1; r.bad = 1;
          exp_q.push_back(r);
        end else begin
          push_sweep(geo_x(g1 ? 1 : 0, g1 ? lane1 : lane0), geo_y(st), W, H,
                     g1 ? col1 : col0);
        end
      end
      if (ack0 === 1'b1 || ack1 === 1'b1 || clear_ack === 1'b1) begin
        sw_plots = 0; sw_first = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // which: 0 ack0, 1 ack1, 2 clear_ack, 3 done. Returns at the matching negedge.
  task automatic wait_sig(input int which, input int limit, output int at);
    bit hit;
    hit = 0;
    at = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = (ack0 === 1'b1);
        1: hit = (ack1 === 1'b1);
        2: hit = (clear_ack === 1'b1);
        default: hit = (done === 1'b1);
      endcase
      if (hit) at = cyc;
    end
    if (!hit) chk($sformatf("timeout_wait_%0d", which), 0, 1);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1 resetn = 1'b0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic next_drive;
    @(posedge clk); #1;
  endtask

  int t, t1, td;
  bit a0, a1;

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // 1: p0 bottom-left box
    step0 = 6'd0; lane0 = 1'b0; col0 = 3'b010; req0 = 1'b1;
    wait_sig(0, 5, t);
    next_drive(); req0 = 1'b0;
    wait_sig(3, 100, td);
    #1;
    chk("t1_done_latency", td - t, 49);
    chk("t1_plots", dn_plots, 48);
    chk("t1_first_x", dn_fx, 16);
    chk("t1_first_y", dn_fy, 117);
    chk("t1_last_x", dn_lx, 31);
    chk("t1_last_y", dn_ly, 119);

    // 2: p1 top-right box
    next_drive();
    step1 = 6'd32; lane1 = 1'b1; col1 = 3'b100; req1 = 1'b1;
    wait_sig(1, 5, t);
    next_drive(); req1 = 1'b0;
    wait_sig(3, 100, td);
    #1;
    chk("t2_first_x", dn_fx, 128);
    chk("t2_first_y", dn_fy, 21);
    chk("t2_last_x", dn_lx, 143);
    chk("t2_last_y", dn_ly, 23);

    // 3: simultaneous requests after reset, p0 wins twice
    apply_reset(1);
    step0 = 6'd5; lane0 = 1'b1; col0 = 3'b001;
    step1 = 6'd10; lane1 = 1'b0; col1 = 3'b110;
    req0 = 1'b1; req1 = 1'b1;
    wait_sig(0, 3, t);
    next_drive(); req0 = 1'b0;
    wait_sig(1, 100, t1);
    chk("t3_ack1_in_done_cycle", t1 - t, 49);
    next_drive(); req1 = 1'b0;
    wait_sig(3, 100, td);
    next_drive(); req0 = 1'b1; req1 = 1'b1;
    wait_sig(0, 3, t);
    next_drive(); req0 = 1'b0;
    wait_sig(1, 100, t1);
    next_drive(); req1 = 1'b0;
    wait_sig(3, 100, td);

    // 4: invalid step
    next_drive();
    step0 = 6'd33; req0 = 1'b1;
    wait_sig(0, 5, t);
    next_drive(); req0 = 1'b0;
    wait_sig(3, 5, td);
    chk("t4_done_latency", td - t, 1);
    chk("t4_bad", bad, 1);
    #1;
    chk("t4_no_plots", dn_plots, 0);

    // 5: clear beats p0; p0 acked in clear's done cycle
    next_drive();
    clear_req = 1'b1; step0 = 6'd3; lane0 = 1'b1; col0 = 3'b111; req0 = 1'b1;
    wait_sig(2, 3, t);
    next_drive(); clear_req = 1'b0;
    wait_sig(0, 19300, t1);
    chk("t5_ack0_latency", t1 - t, 19201);
    chk("t5_done_with_ack0", done, 1);
    #1;
    chk("t5_plots", dn_plots, 19200);
    chk("t5_first_x", dn_fx, 0);
    chk("t5_first_y", dn_fy, 0);
    chk("t5_last_x", dn_lx, 159);
    chk("t5_last_y", dn_ly, 119);
    next_drive(); req0 = 1'b0;
    wait_sig(3, 100, td);

    // 6: reset at pixel 10, held req0 restarts from scratch
    next_drive();
    step0 = 6'd1; lane0 = 1'b0; col0 = 3'b101; req0 = 1'b1;
    wait_sig(0, 5, t);
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_plot_after_reset", plot, 0);
    chk("t6_busy_after_reset", busy, 0);
    chk("t6_done_after_reset", done, 0);
    next_drive(); resetn = 1'b1;
    wait_sig(0, 5, t);
    next_drive(); req0 = 1'b0;
    wait_sig(3, 100, td);
    #1;
    chk("t6_done_latency", td - t, 49);
    chk("t6_plots", dn_plots, 48);
    chk("t6_first_x", dn_fx, 16);
    chk("t6_first_y", dn_fy, 114);

    // 7: randomized requests with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a0 = (ack0 === 1'b1);
      a1 = (ack1 === 1'b1);
      next_drive();
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 399) == 0) resetn = 1'b0;
      if (req0 && a0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        step0 = 6'($urandom_range(0, 35)); lane0 = 1'($urandom);
        col0 = 3'($urandom); req0 = 1'b1;
      end
      if (req1 && a1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        step1 = 6'($urandom_range(0, 35)); lane1 = 1'($urandom);
        col1 = 3'($urandom); req1 = 1'b1;
      end
    end
    resetn = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (120) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/box_plotter.md
# box_plotter

Pixel-sweep engine between the two player step-checkers and the 160x120 VGA adapter. A player raises a draw request carrying a step index, lane and colour. The block arbitrates between player 0, player 1 and a full-screen clear. It then emits one pixel per cycle (x, y, colour, plot) until the rectangle is filled, and reports completion.

## Interface
Parameters:
- BOX_W, default 16: box width in pixels (1..32).
- BOX_H, default 3: box height in pixels (1..3).
- BG_COLOUR, default 3'b000: colour used by the clear sweep.

Ports:
- clk: input, 1 bit, clock.
- resetn: input, 1 bit, reset, synchronous, active-low.
- req0 / req1: input, 1 bit each. Draw request from player 0 / player 1; held high with fields stable until the matching ack.
- step0 / step1: input, 6 bits each. Box index, 0..32 valid; 0 is the bottom box.
- lane0 / lane1: input, 1 bit each. 0 = left lane, 1 = right lane.
- col0 / col1: input, 3 bits each. Fill colour.
- clear_req: input, 1 bit. Request to fill the whole screen with BG_COLOUR; held until clear_ack.
- ack0 / ack1 / clear_ack: output, 1 bit each. Combinational accept strobe; one cycle per accepted request.
- x: output, 8 bits. Pixel column, 0..159.
- y: output, 7 bits. Pixel row, 0..119.
- colour: output, 3 bits. Pixel colour.
- plot: output, 1 bit. Pixel write enable for the VGA adapter.
- busy: output, 1 bit. High in DRAW or CLEAR.
- done: output, 1 bit. One-cycle pulse in the first IDLE cycle after any accepted operation.
- bad: output, 1 bit. One-cycle pulse coincident with done when the accepted step was > 32.

## Operation
- States are IDLE, DRAW and CLEAR.
- Box geometry:
  - x0 = 80*p + (lane ? 48 : 16), where p is the player number.
  - y0 = 117 - 3*step. Compute in 8 bits; the result is always in range for step 0..32.
  - The box covers x0..x0+BOX_W-1 and y0..y0+BOX_H-1.
- Arbitration happens only in IDLE; the priority order is:
  - clear_req first.
  - Then round-robin between req0 and req1.
  - The rr pointer records the last granted player and resets to "p1 last", so p0 wins the first tie.
  - A lone request is granted regardless of rr, and rr updates to the granted player.
- Accept cycle:
  - The ack is asserted combinationally.
  - On that edge the block latches x0, y0 and colour, clears the sweep counters cx and cy to 0, and moves to DRAW or CLEAR.
- Invalid step (> 32):
  - The request is acked and latched.
  - State stays IDLE, with no plot.
  - done and bad pulse the next cycle.
- DRAW:
  - Drives plot=1, x=x0+cx, y=y0+cy and colour=latched colour.
  - cx advances every cycle. At cx=BOX_W-1, cx wraps to 0 and cy increments.
  - After the pixel at (BOX_W-1, BOX_H-1), the block returns to IDLE.
- CLEAR:
  - Same row-major sweep over x 0..159 and y 0..119 with colour=BG_COLOUR (19200 pixels).
  - Then returns to IDLE.
- Outside DRAW and CLEAR, plot=0 and x, y, colour hold their last values.
- Requests arriving during busy are not acked; they wait for IDLE.

## Timing
- Reset (resetn low at an edge) forces the following values the next cycle:
  - state=IDLE; rr = p1 last.
  - x=0, y=0, colour=0.
  - plot=0, busy=0, done=0, bad=0.
  - The ack outputs are 0 while resetn is low.
- Reset mid-sweep aborts immediately, with no further plot cycles. The aborted operation produces no done.
- Draw timing, where the ack is in cycle T and N=BOX_W*BOX_H:
  - plot is high in cycles T+1..T+N, contiguous with no gaps.
  - busy is high in T+1..T+N.
  - done is high in T+N+1.
- A new ack may occur in the same cycle as done (back-to-back operations, with one idle cycle between sweeps).
- Clear timing: plot is high for T+1..T+19200; done is at T+19201.
- x, y, colour and plot are registered and change together. The adapter samples them on the same edge as plot.

## Test plan
- Reset, then req0 with step0=0, lane0=0, col0=3'b010:
  - ack0 is high in T.
  - plot is high for 48 cycles, covering x 16..31 and y 117..119 in row-major order.
  - done is high at T+49.
- req1 with step1=32, lane1=1, col1=3'b100:
  - Pixels cover x 128..143 and y 21..23.
  - The first pixel is (128,21) and the last is (143,23).
- req0 and req1 both asserted right after reset:
  - p0 is acked first.
  - ack1 occurs in p0's done cycle.
  - On the next simultaneous tie, p0 wins again because rr is "p1 last".
- req0 with step0=33: ack0 is high in T; plot stays 0; done=bad=1 at T+1.
- clear_req and req0 asserted together:
  - clear_ack is high.
  - There are 19200 plot cycles with colour 0, ending at (159,119).
  - ack0 occurs in the clear's done cycle.
- resetn pulled low at pixel 10 of a draw:
  - plot=0 and busy=0 on the next cycle, with no done.
  - After release, the still-held req0 is re-acked and its full 48-pixel sweep restarts at (x0,y0).
